// File: rtl/stack_cpu_core.sv
// Multi-cycle stack-machine CPU: one unified memory port, internal operand stack,
// run enable, and sticky overflow/underflow fault halt.
module stack_cpu_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp_count,
    output logic [DATA_W-1:0] tos,
    output logic              z,
    output logic              halted,
    output logic [1:0]        fault
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_ALU1   = 3'd3;
    localparam logic [2:0] S_ALU2   = 3'd4;
    localparam logic [2:0] S_EXNOT  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_OVER  = 2'b01;
    localparam logic [1:0] F_UNDER = 2'b10;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [2:0]        state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] stack [STACK_DEPTH];
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] opnd;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;

    assign opcode   = ir[ADDR_W+2:ADDR_W];
    assign opnd     = ir[ADDR_W-1:0];
    assign top_idx  = IDX_W'(sp_count - 1'b1);
    assign push_idx = IDX_W'(sp_count);

    assign tos       = (sp_count == '0) ? '0 : stack[top_idx];
    assign mem_addr  = (state == S_MEM) ? opnd : pc;
    assign mem_wdata = tos;
    assign mem_we    = en && (state == S_MEM) && (opcode == OP_POP);
    assign halted    = (state == S_HALT);

    // In ALU2 the top entry is the original NOS; B holds the popped top.
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = tos + b;
            OP_SUB:  alu_res = tos - b;
            OP_AND:  alu_res = tos & b;
            default: alu_res = '0;
        endcase
    end

    // Stack storage has no reset: entries above sp_count are never observed.
    always_ff @(posedge clk) begin
        if (en) begin
            case (state)
                S_MEM:   if (opcode == OP_PUSH) stack[push_idx] <= mem_rdata;
                S_ALU2:  stack[top_idx] <= alu_res;
                S_EXNOT: stack[top_idx] <= ~tos;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            b        <= '0;
            sp_count <= '0;
            z        <= 1'b0;
            fault    <= F_NONE;
        end else if (en) begin
            case (state)
                S_FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_PUSH && sp_count == SP_FULL) begin
                        fault <= F_OVER;
                        state <= S_HALT;
                    end else if ((opcode == OP_POP || opcode == OP_NOT || opcode == OP_JZ)
                                 && sp_count == '0) begin
                        fault <= F_UNDER;
                        state <= S_HALT;
                    end else if ((opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND)
                                 && sp_count < SP_W'(2)) begin
                        fault <= F_UNDER;
                        state <= S_HALT;
                    end else begin
                        case (opcode)
                            OP_PUSH, OP_POP:        state <= S_MEM;
                            OP_ADD, OP_SUB, OP_AND: state <= S_ALU1;
                            OP_NOT:                 state <= S_EXNOT;
                            OP_JMP: begin
                                pc    <= opnd;
                                state <= S_FETCH;
                            end
                            default: begin
                                if (tos == '0) pc <= opnd;
                                state <= S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (opcode == OP_PUSH) sp_count <= sp_count + 1'b1;
                    else                   sp_count <= sp_count - 1'b1;
                    state <= S_FETCH;
                end
                S_ALU1: begin
                    b        <= tos;
                    sp_count <= sp_count - 1'b1;
                    state    <= S_ALU2;
                end
                S_ALU2: begin
                    z     <= (alu_res == '0);
                    state <= S_FETCH;
                end
                S_EXNOT: begin
                    z     <= (~tos == '0);
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed bench for stack_cpu_core: small programs with hand-computed results,
// fault halts, control flow, run enable and mid-instruction reset.
module tb_stack_cpu_core;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [4:0] pc;
    logic [3:0] sp_count;
    logic [7:0] tos;
    logic       z;
    logic       halted;
    logic [1:0] fault;

    logic [7:0] mem [32];
    logic [7:0] img [32];
    logic       ld_en;

    int n_tests;
    int n_fail;
    int we_cnt;
    int wr_edge;

    stack_cpu_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc        (pc),
        .sp_count  (sp_count),
        .tos       (tos),
        .z         (z),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock cycles; called and returning at a falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            if (mem_we) we_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        ld_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_sp", 32'(sp_count), 32'd0);
        check("rst_flags", {27'd0, z, halted, fault, mem_we}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst_n  = 1'b1;
        we_cnt = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        we_cnt  = 0;
        rst_n   = 1'b1;
        en      = 1'b0;
        ld_en   = 1'b0;
        clear_img();
        @(negedge clk);

        // Arithmetic: 9 - 4 stored to mem[22]
        clear_img();
        img[0] = 8'h14; img[1] = 8'h15; img[2] = 8'h60; img[3] = 8'h36;
        img[20] = 8'd9; img[21] = 8'd4;
        do_reset();
        wr_edge = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_we) begin
                wr_edge = i + 1;
                break;
            end
            step(1);
        end
        check("pop_edge", 32'(wr_edge), 32'd13);
        check("pop_addr", 32'(mem_addr), 32'd22);
        step(1);
        check("arith_mem22", 32'(mem[22]), 32'd5);
        check("arith_sp", 32'(sp_count), 32'd0);
        check("arith_z", 32'(z), 32'd0);
        check("arith_pc", 32'(pc), 32'd4);

        // Logic: AND, NOT, SUB of equal values
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h0B; img[2] = 8'h80; img[3] = 8'hA0;
        img[4] = 8'h0D; img[5] = 8'h60;
        img[10] = 8'hF0; img[11] = 8'h3C; img[13] = 8'hCF;
        do_reset();
        step(10);
        check("and_tos", 32'(tos), 32'h30);
        check("and_z", 32'(z), 32'd0);
        check("and_sp", 32'(sp_count), 32'd1);
        step(3);
        check("not_tos", 32'(tos), 32'hCF);
        check("not_z", 32'(z), 32'd0);
        step(7);
        check("sub0_tos", 32'(tos), 32'h00);
        check("sub0_z", 32'(z), 32'd1);
        check("sub0_sp", 32'(sp_count), 32'd1);

        // Overflow: nine pushes into an 8-deep stack
        clear_img();
        for (int i = 0; i < 9; i++) img[i] = 8'h1F;
        img[31] = 8'h11;
        do_reset();
        step(25);
        check("ovf_not_yet", 32'(halted), 32'd0);
        step(1);
        check("ovf_halted", 32'(halted), 32'd1);
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_sp", 32'(sp_count), 32'd8);
        check("ovf_pc", 32'(pc), 32'd9);
        check("ovf_tos", 32'(tos), 32'h11);
        step(20);
        check("ovf_frozen_pc", 32'(pc), 32'd9);
        check("ovf_fault_sticky", 32'(fault), 32'd1);
        check("ovf_no_we", 32'(we_cnt), 32'd0);

        // Underflow: ADD with one entry
        clear_img();
        img[0] = 8'h14; img[1] = 8'h40; img[20] = 8'd7;
        do_reset();
        step(8);
        check("uadd_fault", 32'(fault), 32'd2);
        check("uadd_halted", 32'(halted), 32'd1);
        check("uadd_sp", 32'(sp_count), 32'd1);

        // Underflow: POP on empty stack
        clear_img();
        img[0] = 8'h25;
        do_reset();
        step(4);
        check("upop_fault", 32'(fault), 32'd2);
        check("upop_halted", 32'(halted), 32'd1);
        check("upop_no_we", 32'(we_cnt), 32'd0);

        // JZ taken with tos == 0
        clear_img();
        img[0] = 8'h14; img[1] = 8'hEA; img[20] = 8'd0;
        do_reset();
        step(5);
        check("jz_taken_pc", 32'(pc), 32'd10);
        check("jz_taken_sp", 32'(sp_count), 32'd1);

        // JZ not taken with tos == 3
        clear_img();
        img[0] = 8'h14; img[1] = 8'hEA; img[20] = 8'd3;
        do_reset();
        step(5);
        check("jz_fall_pc", 32'(pc), 32'd2);
        check("jz_fall_sp", 32'(sp_count), 32'd1);

        // JMP 31 then fetch at 31 wraps pc to 0
        clear_img();
        img[0] = 8'hDF; img[31] = 8'h14; img[20] = 8'h66;
        do_reset();
        step(2);
        check("jmp_pc", 32'(pc), 32'd31);
        step(1);
        check("wrap_pc", 32'(pc), 32'd0);
        step(2);
        check("wrap_push_tos", 32'(tos), 32'h66);

        // Enable: stall inside PUSH MEM, then inside POP MEM
        clear_img();
        img[0] = 8'h14; img[1] = 8'h39; img[20] = 8'h5A;
        do_reset();
        step(2);
        en = 1'b0;
        step(5);
        check("en_pc", 32'(pc), 32'd1);
        check("en_sp", 32'(sp_count), 32'd0);
        check("en_addr", 32'(mem_addr), 32'd20);
        en = 1'b1;
        step(1);
        check("en_push_sp", 32'(sp_count), 32'd1);
        check("en_push_tos", 32'(tos), 32'h5A);
        step(2);
        check("pop_we_on", {27'd0, mem_addr}, 32'd25);
        check("pop_we_hi", 32'(mem_we), 32'd1);
        en = 1'b0;
        #1;
        check("pop_we_gated", 32'(mem_we), 32'd0);
        step(3);
        check("pop_stall_sp", 32'(sp_count), 32'd1);
        check("pop_stall_mem", 32'(mem[25]), 32'd0);
        en = 1'b1;
        step(1);
        check("pop_done_mem", 32'(mem[25]), 32'h5A);
        check("pop_done_sp", 32'(sp_count), 32'd0);

        // Reset pulsed during ALU2 of ADD
        clear_img();
        img[0] = 8'h14; img[1] = 8'h15; img[2] = 8'h40;
        img[20] = 8'd9; img[21] = 8'd4;
        do_reset();
        step(9);
        check("pre_rst_sp", 32'(sp_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_sp", 32'(sp_count), 32'd0);
        check("mid_rst_tos", 32'(tos), 32'd0);
        check("mid_rst_flags", {27'd0, z, halted, fault, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("restart_pc", 32'(pc), 32'd1);
        step(2);
        check("restart_tos", 32'(tos), 32'd9);
        step(7);
        check("restart_add", 32'(tos), 32'd13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_cpu_core.md
Name: stack_cpu_core

Overview:
- Parametrised multi-cycle stack-machine CPU core with a single unified memory port, an internal operand stack, and an integrated FSM controller.
- Generalises the fixed 8-bit stack CPU to configurable data width, address width and stack depth.
- Adds a run-enable input, stack overflow/underflow detection with sticky fault halt, and status outputs.
- The memory (instructions and data) is external; it is read combinationally and written synchronously.

Parameters:
- DATA_W, 8, data and instruction word width; must be ≥ ADDR_W+3.
- ADDR_W, 5, memory address width; the PC wraps modulo 2^ADDR_W.
- STACK_DEPTH, 8, number of operand stack entries; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; when low, all state holds and mem_we=0.
- mem_addr  out  ADDR_W  memory address (combinational from state).
- mem_rdata  in  DATA_W  memory read data for mem_addr, same cycle.
- mem_wdata  out  DATA_W  write data (always equals TOS).
- mem_we  out  1  write strobe; memory writes on the clk edge when high.
- pc  out  ADDR_W  program counter.
- sp_count  out  clog2(STACK_DEPTH+1)  current stack depth (0..STACK_DEPTH).
- tos  out  DATA_W  top of stack; 0 when empty.
- z  out  1  zero flag, set from the last ALU/NOT result.
- halted  out  1  core stopped due to a fault.
- fault  out  2  fault code: 00 none, 01 overflow, 10 underflow. Sticky.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; pc=0, IR=0, B=0, sp_count=0, z=0, halted=0, fault=00.
  - Stack contents are don't-care; mem_we=0, mem_addr=0.
- Instruction fields: opcode = IR[ADDR_W+2:ADDR_W]; operand addr = IR[ADDR_W-1:0]; bits above are ignored.
- Opcodes:
  - 000 PUSH a: push mem[a].
  - 001 POP a: mem[a] ← TOS, pop.
  - 010 ADD; 011 SUB; 100 AND.
  - 101 NOT.
  - 110 JMP a.
  - 111 JZ a: jump if TOS==0; does not pop.
- Binary ops: top is popped into B, then NOS ← NOS op B. SUB = NOS − TOS, modulo 2^DATA_W. Net depth change is −1.
- FSM states: FETCH, DECODE, MEM, ALU1, ALU2, EXNOT, HALT. Transitions below occur only on edges where en=1.
- FETCH: mem_addr=pc; IR←mem_rdata; pc←pc+1 (31→0 wraps). → DECODE.
- DECODE: checks first, in this order:
  - PUSH with sp_count==STACK_DEPTH → fault=01, HALT.
  - POP/NOT/JZ with sp_count==0 → fault=10, HALT.
  - ADD/SUB/AND with sp_count<2 → fault=10, HALT.
  - Otherwise:
    - PUSH/POP → MEM.
    - ADD/SUB/AND → ALU1.
    - NOT → EXNOT.
    - JMP: pc←a, → FETCH.
    - JZ: if tos==0 then pc←a; → FETCH.
- MEM: mem_addr=a.
  - PUSH: stack[sp]←mem_rdata, sp+1.
  - POP: mem_we=1, mem_wdata=TOS, sp−1.
  - → FETCH.
- ALU1: B←TOS, sp−1. → ALU2.
- ALU2: TOS←TOS op B; z←(result==0). → FETCH.
- EXNOT: TOS←~TOS; z←(result==0). → FETCH.
- HALT: absorbing until reset; mem_we=0; pc, stack and flags are frozen.
- Latency, in cycles with en held high:
  - PUSH/POP: 3.
  - ADD/SUB/AND: 4.
  - NOT: 3.
  - JMP/JZ: 2.
  - Fault: detected in DECODE; halted=1 from the next edge.
- en=0: no register changes, mem_we forced 0, mem_addr keeps its state-derived value. Resuming continues exactly where it stopped.
- mem_addr outside MEM equals pc.
- Async reset mid-instruction aborts it immediately; no partial memory write after the reset is asserted.

Test Plan:
- Arithmetic: mem[20]=9, mem[21]=4; program at 0: PUSH 20, PUSH 21, SUB, POP 22.
  - mem[22]=5, sp_count=0, z=0, pc=4.
  - Exactly 13 cycles from reset release to the POP write.
- Logic: PUSH 0xF0, PUSH 0x3C, AND → tos=0x30, z=0; then NOT → tos=0xCF; SUB of equal values → tos=0x00, z=1.
- Overflow: 9 consecutive PUSH (depth 8) → the 9th halts with fault=01, halted=1, sp_count=8, pc=9; no further mem_we ever asserted.
- Underflow:
  - ADD with sp_count=1 → fault=10, sp_count unchanged at 1.
  - POP on empty → fault=10.
- Control flow:
  - JZ with tos=0 → pc=target, sp_count unchanged.
  - JZ with tos=3 → falls through.
  - JMP 31; instruction at 31 fetched → pc wraps to 0.
- Enable/reset:
  - en=0 for 5 cycles during PUSH MEM → state, pc, sp_count unchanged; completes after en=1.
  - rst_n pulsed low in ALU2 → all outputs at reset values immediately; restart fetches from 0.
